// File: rtl/keypad_pkg.sv
// keypad_pkg: keycodes, scan FSM states and column idle level shared by the keypad scanner.
package keypad_pkg;
  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [2:0] COL_IDLE = 3'b111;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
endpackage

// File: rtl/keypad_slot_decode.sv
// keypad_slot_decode: maps one scan slot's active-low column sample to a keycode.
module keypad_slot_decode
  import keypad_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [2:0] column,
  output logic [3:0] code
);
  logic [1:0] idx;
  assign idx = (column == 3'b011) ? 2'd0 :
               (column == 3'b101) ? 2'd1 :
               (column == 3'b110) ? 2'd2 : 2'd3;
  always_comb begin
    code = KEY_NONE;
    if (sel < 3'd4 && idx != 2'd3)
      code = (sel == 3'd3) ? ((idx == 2'd0) ? KEY_STAR : (idx == 2'd1) ? KEY_0 : KEY_HASH)
                           : 4'({1'b0, sel}) * 4'd3 + 4'(idx) + 4'd1;
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: frame-based keypad scan with a debounce FSM and one strobe per accepted press.
// Defining KEYPAD_AUTOREPEAT_EN re-strobes a held key after REPEAT_DLY frames, then every REPEAT_PER.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_ROWS       = 6,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DLY      = 32,
  parameter int REPEAT_PER      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [2:0] column,
  output logic [2:0] sel,
  output logic       key_valid,
  output logic [3:0] keycode,
  output logic       key_held
);
  if (SCAN_ROWS < 4 || SCAN_ROWS > 8) begin : g_bad_rows
    $error("SCAN_ROWS must be 4..8");
  end
  if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15) begin : g_bad_deb
    $error("DEBOUNCE_FRAMES must be 2..15");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_rpt
    $error("REPEAT_DLY and REPEAT_PER must be positive");
  end
  state_t     state, state_n;
  logic [3:0] acc, dec, result, cand, cand_n, cnt, cnt_n, cnt_inc, keycode_n;
  logic       last, fire, strobe;
  keypad_slot_decode u_dec (.sel(sel), .column(column), .code(dec));
  assign last     = (sel == 3'(SCAN_ROWS - 1));
  // lower slots are scanned first, so the first key seen in a frame wins
  assign result   = (acc != KEY_NONE) ? acc : dec;
  assign cnt_inc  = cnt + 4'd1;
  assign key_held = (state == PRESSED) || (state == RELEASE);
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cand_n    = cand;
    keycode_n = keycode;
    fire      = 1'b0;
    case (state)
      IDLE:
        if (result != KEY_NONE) begin
          state_n = DEBOUNCE;
          cand_n  = result;
          cnt_n   = 4'd1;
        end
      DEBOUNCE:
        if (result == cand) begin
          cnt_n = cnt_inc;
          if (cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
            state_n   = PRESSED;
            keycode_n = cand;
            fire      = 1'b1;
          end
        end else if (result == KEY_NONE) begin
          state_n = IDLE;
        end else begin
          cand_n = result;
          cnt_n  = 4'd1;
        end
      PRESSED:
        if (result != cand) begin
          state_n = RELEASE;
          cnt_n   = (result == KEY_NONE) ? 4'd1 : 4'd0;
        end
      RELEASE:
        if (result == KEY_NONE) begin
          cnt_n = cnt_inc;
          if (cnt_inc == 4'(DEBOUNCE_FRAMES)) state_n = IDLE;
        end else if (result == cand) begin
          state_n = PRESSED;
        end else begin
          cnt_n = 4'd0;
        end
    endcase
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [15:0] rpt, rpt_n, rpt_inc;
  logic        rep, rep_n, hold, rpt_fire;
  // rep selects the initial delay or the steady repeat period
  always_comb begin
    rpt_inc  = rpt + 16'd1;
    hold     = (state == PRESSED) && (result == cand);
    rpt_fire = hold && (rpt_inc == (rep ? 16'(REPEAT_PER) : 16'(REPEAT_DLY)));
    rpt_n    = hold ? (rpt_fire ? 16'd0 : rpt_inc) : 16'd0;
    rep_n    = hold && (rep || rpt_fire);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rpt <= '0;
      rep <= 1'b0;
    end else if (scan_en && last) begin
      rpt <= rpt_n;
      rep <= rep_n;
    end
  assign strobe = fire || rpt_fire;
`else
  assign strobe = fire;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sel       <= '0;
      acc       <= KEY_NONE;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= KEY_NONE;
      keycode   <= KEY_NONE;
      key_valid <= 1'b0;
    end else begin
      key_valid <= scan_en && last && strobe;
      if (scan_en) begin
        sel <= last ? 3'd0 : sel + 3'd1;
        acc <= last ? KEY_NONE : result;
        if (last) begin
          state   <= state_n;
          cnt     <= cnt_n;
          cand    <= cand_n;
          keycode <= keycode_n;
        end
      end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboarded random and directed frames against a run-length keypad model.
module tb_keypad_scanner;
  localparam int SR = 6;
  localparam int DF = 3;
  localparam int RD = 4;
  localparam int RP = 2;
  localparam logic [3:0] NONE = 4'hF;
  localparam logic [2:0] COLS [3] = '{3'b011, 3'b101, 3'b110};
  localparam logic [3:0] KEYMAP [4][3] = '{'{4'h1, 4'h2, 4'h3}, '{4'h4, 4'h5, 4'h6},
                                           '{4'h7, 4'h8, 4'h9}, '{4'hA, 4'h0, 4'hB}};
  logic clk = 0, reset = 0, scan_en = 0;
  logic [2:0] column, sel;
  logic key_valid, key_held, prev_valid = 0;
  logic [3:0] keycode;
  logic [2:0] plan [8];
  logic [3:0] exp_q [$];
  int tests = 0, fails = 0;
  logic [3:0] m_held = NONE, m_run_key = NONE, m_keycode = NONE;
  int m_run_len = 0, m_streak = -1;

  keypad_scanner #(.SCAN_ROWS(SR), .DEBOUNCE_FRAMES(DF), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .column(column),
    .sel(sel), .key_valid(key_valid), .keycode(keycode), .key_held(key_held));

  always #5 clk = ~clk;
  assign column = plan[sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      check("strobe_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got keycode %0h expected no strobe at %0t", keycode, $time);
      end else check("strobe_code", keycode, exp_q.pop_front());
    end
    prev_valid <= key_valid;
  end

  function automatic logic [3:0] frame_result();
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 3; c++)
        if (plan[s] == COLS[c]) return KEYMAP[s][c];
    return NONE;
  endfunction

  task automatic model_reset();
    m_held = NONE; m_run_key = NONE; m_run_len = 0; m_streak = -1; m_keycode = NONE;
    exp_q.delete();
  endtask

  // a key is accepted after DF identical frames with nothing held; released after DF empty frames
  task automatic model_frame(input logic [3:0] r);
    if (r == m_run_key) m_run_len++;
    else begin m_run_key = r; m_run_len = 1; end
    if (m_held == NONE) begin
      if (r != NONE && m_run_len == DF) begin
        m_held = r; m_keycode = r; m_streak = 0; exp_q.push_back(r);
      end
    end else if (r == m_held) begin
      m_streak = (m_streak < 0) ? 0 : m_streak + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
      if (m_streak == RD || (m_streak > RD && (m_streak - RD) % RP == 0)) exp_q.push_back(r);
`endif
    end else begin
      m_streak = -1;
      if (r == NONE && m_run_len == DF) m_held = NONE;
    end
  endtask

  task automatic step();
    int gap;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    if (gap > 0) begin
      scan_en = 0;
      repeat (gap) @(posedge clk);
      #1;
    end
    scan_en = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k);
    for (int s = 0; s < 8; s++) plan[s] = 3'b111;
    if (k >= 0) plan[k / 3] = COLS[k % 3];
  endtask

  task automatic run_frame();
    for (int s = 0; s < SR; s++) begin
      step();
      check("sel", sel, (s + 1) % SR);
    end
    model_frame(frame_result());
    check("keycode", keycode, m_keycode);
    check("key_held", key_held, m_held != NONE);
  endtask

  task automatic frames(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      set_key(k);
      run_frame();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int left = 0, intent = 12;
    set_key(-1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel, 0);
    check("rst_keycode", keycode, NONE);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    reset = 1;
    frames(-1, 10);
    frames(7, 5);
    frames(-1, 3);
    for (int i = 0; i < 6; i++) frames((i % 2 == 0) ? 0 : -1, 1);
    frames(-1, 3);
    frames(1, 4);
    for (int i = 0; i < 2; i++) begin
      set_key(1);
      plan[2] = 3'b110;
      run_frame();
    end
    frames(8, 2);
    frames(-1, 3);
    frames(8, 4);
    frames(-1, 4);
    frames(10, 1);
    for (int s = 0; s < 3; s++) step();
    reset = 0;
    #1;
    model_reset();
    check("mid_rst_sel", sel, 0);
    check("mid_rst_keycode", keycode, NONE);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_held", key_held, 0);
    scan_en = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    frames(10, 4);
    frames(-1, 3);
    frames(11, 12);
    frames(-1, 4);
    for (int f = 0; f < 300; f++) begin
      if (left == 0) begin
        left = $urandom_range(1, 7);
        intent = $urandom_range(0, 15);
      end
      left--;
      set_key(intent < 12 ? intent : -1);
      if ($urandom_range(0, 9) == 0) plan[$urandom_range(0, 5)] = 3'($urandom);
      run_frame();
    end
    scan_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check("pending_strobes", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 3-column, 4-row game keypad and delivers one debounced, single-shot keycode per physical press to the movement and control logic downstream. It drives the shared `sel` scan index, which is also consumed by the seven-segment scan, and replaces the ad-hoc decode, edge-valid and buffer chain with one frame-based debounce state machine. Downstream blocks act only on the `key_valid` strobe.

## Interface
- `SCAN_ROWS`, default 6: scan slots per frame. `sel` counts 0..SCAN_ROWS-1. Only slots 0–3 carry keys; slots 4 and up are display-only. Legal range 4–8.
- `DEBOUNCE_FRAMES`, default 3: consecutive identical frames required to accept a press or a release. Legal range 2–15.
- `REPEAT_DLY`, default 32: frames from acceptance to the first auto-repeat.
- `REPEAT_PER`, default 8: frames between subsequent auto-repeats.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `scan_en`  in  1  one-cycle scan strobe from the frequency divider. All state is frozen while it is low.
- `column`  in  3  keypad column lines, active-low. Idle value is 3'b111.
- `sel`  out  3  current scan slot.
- `key_valid`  out  1  one-cycle strobe: a new key was accepted, or an auto-repeat fired.
- `keycode`  out  4  code of the last accepted key. Holds its value between strobes.
- `key_held`  out  1  high while the accepted key is still considered down.

## Operation
- **Key map**, by slot:
  - Slot 0: `column` 011→1, 101→2, 110→3.
  - Slot 1: 011→4, 101→5, 110→6.
  - Slot 2: 011→7, 101→8, 110→9.
  - Slot 3: 011→4'hA (`*`), 101→0, 110→4'hB (`#`).
  - Anything else, including multiple columns low or slots 4 and up, decodes to NONE (4'hF).
- **Scan:** on each `scan_en`, sample `column` for the current `sel`, then advance `sel`, wrapping from SCAN_ROWS-1 to 0.
- **Frame result:** the first non-NONE decode in the frame, in slot order. If two keys appear in different slots, the lower slot wins.
- **Frame end:** the `scan_en` edge at `sel`=SCAN_ROWS-1. On this edge the FSM evaluates the frame result, including the last slot's sample, and the frame accumulator is cleared.
- **FSM** (4 bits of counter `cnt`; `cand` is the candidate code):
  - IDLE:
    - result ≠ NONE → `cand`=result, `cnt`=1, go to DEBOUNCE.
  - DEBOUNCE:
    - result = `cand` → `cnt`+1. When `cnt` reaches DEBOUNCE_FRAMES: go to PRESSED, `keycode`=`cand`, pulse `key_valid`.
    - result = NONE → go to IDLE.
    - any other key → `cand`=result, `cnt`=1, stay in DEBOUNCE.
  - PRESSED:
    - result = `cand` → stay.
    - otherwise → go to RELEASE, `cnt`=1 if result = NONE, else `cnt`=0.
  - RELEASE:
    - result = NONE → `cnt`+1. When `cnt` reaches DEBOUNCE_FRAMES, go to IDLE.
    - result = `cand` → return to PRESSED. No strobe.
    - other key → `cnt`=0, stay in RELEASE.
- `key_held` is 1 in PRESSED and RELEASE.
- A new, different key is not accepted until the previous key completes its release.

## Timing
- Reset values: `sel`=0, state IDLE, `keycode`=4'hF, `key_valid`=0, `key_held`=0, `cnt`=0.
- `key_valid`, `keycode` and `key_held` are registered and change on the frame-end edge. `key_valid` is high for exactly one `clk` cycle.
- Latency: a press stable from frame k is accepted at the end of frame k+DEBOUNCE_FRAMES-1.
- `scan_en` held continuously high is legal: one slot per clock.
- Reset asserted mid-frame or mid-debounce aborts immediately. No strobe is emitted on reset release.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - While in PRESSED with result = `cand`, a frame counter starts at acceptance.
  - `key_valid` re-pulses with the same `keycode` after REPEAT_DLY frames, then every REPEAT_PER frames.
  - The counter clears on leaving PRESSED. A RELEASE→PRESSED bounce restarts the delay.
- `KEYPAD_AUTOREPEAT_EN` undefined: exactly one strobe per accepted press, and the repeat counter is absent.

## Structure
- Shared package `keypad_pkg` holds:
  - keycode constants KEY_0..KEY_9, KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_NONE=4'hF;
  - the FSM state encoding (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the idle column value 3'b111.
- One sub-module, `keypad_slot_decode`: purely combinational (`sel`, `column`) → code per the key map.

## Test plan
All scenarios use SCAN_ROWS=6 and DEBOUNCE_FRAMES=3.
1. Reset low, then high with `column`=111 for 10 frames → `sel` cycles 0..5, `key_valid` never asserts, `keycode`=4'hF.
2. Drive `column`=101 while `sel`=2, in every frame for 5 frames → a single `key_valid` at the end of frame 3, `keycode`=4'h8, `key_held`=1; after 3 idle frames, `key_held`=0.
3. Bounce: key 1 (slot 0, 011) present in alternating frames for 6 frames → no `key_valid`.
4. Hold key 2, then add key 9 (slot 2, 110) → `keycode` stays 2; key 9 is accepted only after 3 clean NONE frames followed by 3 frames of 9.
5. Assert reset during frame 2 of debouncing key 0 → outputs return to reset values at once; no strobe after release until a full new debounce completes.
6. With `KEYPAD_AUTOREPEAT_EN`, REPEAT_DLY=4, REPEAT_PER=2, hold `#` for 12 frames → strobes at frames 3, 7, 9, 11, all with `keycode`=4'hB; without the macro, only the frame-3 strobe.
